ahb_rr_arbiter: RTL and testbench

- Round-robin AHB manager arbiter that drives the grant vector consumed by ahbmmgr's address/data multiplexer.
- Sits directly upstream of the manager mux.
- Takes per-manager requests plus the muxed address-phase controls of the currently granted manager, as seen on the main bus.
- Produces an address-phase grant and a data-phase grant.
- Holds the grant across fixed-length bursts, undefined-length INCR bursts and locked sequences.

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/ahb_rr_arbiter_if.sv | 30 +++
 rtl/ahb_rr_pick.sv | 36 +++
 rtl/ahb_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types for the round-robin manager arbiter: transfer/burst encodings,
// arbiter FSM states and the fixed-burst length decode.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BURST = 2'd1,
        INCRB = 2'd2,
        LOCK  = 2'd3
    } arb_state_t;

    localparam int BEAT_W = 5;

    // Beats in a fixed-length burst; SINGLE and INCR have no fixed length.
    function automatic logic [BEAT_W-1:0] burst_len(input hburst_t b);
        case (b)
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// Bus-side signal bundle of the arbiter: requests and muxed address-phase controls in,
// address/data-phase grants out.
interface ahb_rr_arbiter_if #(
    parameter int MANAGERS = 4
);
    import ahb_pkg::*;

    localparam int IDW = $clog2(MANAGERS);

    logic [MANAGERS-1:0] req;
    htrans_t             HTRANS;
    hburst_t             HBURST;
    logic                HMASTLOCK;
    logic                HREADY;
    logic [MANAGERS-1:0] granted;
    logic [MANAGERS-1:0] grantedD;
    logic [IDW-1:0]      grant_id;
    logic                lock_timeout;

    modport slave (
        input  req, HTRANS, HBURST, HMASTLOCK, HREADY,
        output granted, grantedD, grant_id, lock_timeout
    );

    modport master (
        output req, HTRANS, HBURST, HMASTLOCK, HREADY,
        input  granted, grantedD, grant_id, lock_timeout
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Rotating-priority search: first requester strictly after ptr_i, wrapping, so the
// last owner is considered last.
module ahb_rr_pick #(
    parameter int MANAGERS = 4,
    parameter int IDW      = $clog2(MANAGERS)
) (
    input  logic [MANAGERS-1:0] req_i,
    input  logic [IDW-1:0]      ptr_i,
    output logic [MANAGERS-1:0] onehot_o,
    output logic [IDW-1:0]      idx_o,
    output logic                valid_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = ptr_i;
        for (int i = 0; i < MANAGERS; i++) begin
            cand = (cand == IDW'(MANAGERS - 1)) ? '0 : cand + IDW'(1);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MANAGERS; gi++) begin : g_onehot
            assign onehot_o[gi] = valid_o && (idx_o == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB manager arbiter holding the grant across bursts and locked sequences.
// Optional forced lock release after LOCK_MAX cycles: define AHB_ARB_LOCK_TIMEOUT_EN.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int MANAGERS    = 4,
    parameter int DEFAULT_MGR = 0,
    parameter int LOCK_MAX    = 64
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_rr_arbiter_if.slave bus
);

    localparam int                  IDW    = $clog2(MANAGERS);
    localparam logic [MANAGERS-1:0] DEF_OH = MANAGERS'(1) << DEFAULT_MGR;
    localparam logic [IDW-1:0]      DEF_ID = IDW'(DEFAULT_MGR);

    arb_state_t          state_q, state_d;
    logic [MANAGERS-1:0] granted_q, granted_d;
    logic [MANAGERS-1:0] granted_dp_q;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   fixed_len;
    logic                rearb;
    logic                lock_expired;

    logic [MANAGERS-1:0] win_oh;
    logic [IDW-1:0]      win_idx;
    logic                win_valid;

    ahb_rr_pick #(
        .MANAGERS (MANAGERS),
        .IDW      (IDW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .valid_o  (win_valid)
    );

    assign fixed_len = burst_len(bus.HBURST);

    always_comb begin
        state_d    = state_q;
        granted_d  = granted_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        rearb      = 1'b0;
        case (state_q)
            ARB: begin
                // Lock outranks any burst type it arrives with.
                if (bus.HMASTLOCK && bus.HTRANS != IDLE) begin
                    state_d = LOCK;
                end else if (bus.HTRANS == NONSEQ && fixed_len != '0) begin
                    state_d = BURST;
                    beat_d  = fixed_len - 5'd1;
                end else if (bus.HTRANS == NONSEQ && bus.HBURST == INCR) begin
                    state_d = INCRB;
                end else begin
                    rearb = 1'b1;
                end
            end
            BURST: begin
                case (bus.HTRANS)
                    SEQ: begin
                        if (beat_q == 5'd1) rearb = 1'b1;
                        else                beat_d = beat_q - 5'd1;
                    end
                    BUSY:    ;
                    default: rearb = 1'b1;
                endcase
            end
            INCRB: begin
                if (bus.HTRANS == IDLE || bus.HTRANS == NONSEQ) rearb = 1'b1;
            end
            LOCK: begin
                if (!bus.HMASTLOCK || lock_expired) rearb = 1'b1;
            end
            default: rearb = 1'b1;
        endcase

        // Pointer only advances when a real requester wins, not on the idle default.
        if (rearb) begin
            state_d = ARB;
            beat_d  = '0;
            if (win_valid) begin
                granted_d  = win_oh;
                grant_id_d = win_idx;
                ptr_d      = win_idx;
            end else begin
                granted_d  = DEF_OH;
                grant_id_d = DEF_ID;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ARB;
            granted_q    <= DEF_OH;
            granted_dp_q <= DEF_OH;
            grant_id_q   <= DEF_ID;
            ptr_q        <= DEF_ID;
            beat_q       <= '0;
        end else if (bus.HREADY) begin
            state_q      <= state_d;
            granted_q    <= granted_d;
            granted_dp_q <= granted_q;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            beat_q       <= beat_d;
        end
    end

    assign bus.granted  = granted_q;
    assign bus.grantedD = granted_dp_q;
    assign bus.grant_id = grant_id_q;

`ifdef AHB_ARB_LOCK_TIMEOUT_EN
    localparam int             LCW      = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);

    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_to_q;

    assign lock_expired = (lock_cnt_q == LOCK_LIM);

    // Counts every clock in LOCK, wait states included, so a stalled lock still expires.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q != LOCK || (bus.HREADY && state_d != LOCK)) begin
            lock_cnt_d = '0;
        end else if (!lock_expired) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_cnt_q <= '0;
            lock_to_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_to_q  <= bus.HREADY && (state_q == LOCK) && bus.HMASTLOCK && lock_expired;
        end
    end

    assign bus.lock_timeout = lock_to_q;
`else
    logic unused_lock_cfg;

    assign lock_expired     = 1'b0;
    assign bus.lock_timeout = 1'b0;
    assign unused_lock_cfg  = (LOCK_MAX > 0);
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: stimulus queues expected grants, a monitor
// compares them one clock later.
module tb_ahb_rr_arbiter;
    import ahb_pkg::*;

    localparam int M = 4;
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
    localparam int LOCK_XFERS = 9;
`else
    localparam int LOCK_XFERS = 10;
`endif

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;

    always #5 HCLK = ~HCLK;

    ahb_rr_arbiter_if #(.MANAGERS(M)) bus ();

    ahb_rr_arbiter #(
        .MANAGERS    (M),
        .DEFAULT_MGR (0),
        .LOCK_MAX    (8)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    typedef struct {
        int id;
        int did;
        int to;
        int n;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   step_no      = 0;
    int   cur          = 0;

    function automatic void check(input string name, input int n, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL step %0d %s: got %0d expected %0d", n, name, got, want);
        end
    endfunction

    task automatic step(input logic [3:0] r, input htrans_t t, input hburst_t b, input logic l,
                        input logic rdy, input int id, input int did, input int to);
        @(negedge HCLK);
        bus.req       = r;
        bus.HTRANS    = t;
        bus.HBURST    = b;
        bus.HMASTLOCK = l;
        bus.HREADY    = rdy;
        step_no++;
        sb_q.push_back('{id, did, to, step_no});
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge HCLK);
            #2;
            k++;
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("grant_id", e.n, int'(bus.grant_id), e.id);
                check("granted", e.n, int'(bus.granted), 1 << e.id);
                check("grantedD", e.n, int'(bus.grantedD), 1 << e.did);
                check("lock_timeout", e.n, int'(bus.lock_timeout), e.to);
                $display("[TB] step %0d: id=%0d granted=%b grantedD=%b to=%0d", e.n,
                         bus.grant_id, bus.granted, bus.grantedD, bus.lock_timeout);
            end
        end
    end

    initial begin
        bus.req       = '0;
        bus.HTRANS    = IDLE;
        bus.HBURST    = SINGLE;
        bus.HMASTLOCK = 1'b0;
        bus.HREADY    = 1'b1;
        #2 HRESETn = 1'b0;

        // Reset and idle release
        step(4'b0000, IDLE, SINGLE, 0, 1, 0, 0, 0);
        step(4'b0000, IDLE, SINGLE, 0, 1, 0, 0, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(4'b0000, IDLE, SINGLE, 0, 1, 0, 0, 0);
        step(4'b0000, IDLE, SINGLE, 0, 1, 0, 0, 0);

        // Round robin with singles
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 1, 0, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 2, 1, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 3, 2, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 0, 3, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 1, 0, 0);

        // INCR4 from manager 2 with BUSY and a stall
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 2, 1, 0);
        step(4'b1111, NONSEQ, INCR4,  0, 1, 2, 2, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 2, 2, 0);
        step(4'b1111, BUSY,   INCR4,  0, 1, 2, 2, 0);
        step(4'b1111, SEQ,    INCR4,  0, 0, 2, 2, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 2, 2, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 3, 2, 0);
        step(4'b1111, IDLE,   SINGLE, 0, 1, 0, 3, 0);

        // Locked sequence from manager 1
        step(4'b0010, NONSEQ, SINGLE, 0, 1, 1, 0, 0);
        step(4'b1111, NONSEQ, SINGLE, 1, 1, 1, 1, 0);
        for (int k = 2; k <= LOCK_XFERS; k++) step(4'b1111, NONSEQ, SINGLE, 1, 1, 1, 1, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 2, 1, 0);

        // WRAP8 terminated early, then a fresh INCR4
        step(4'b1000, IDLE,   SINGLE, 0, 1, 3, 2, 0);
        step(4'b1111, NONSEQ, WRAP8,  0, 1, 3, 3, 0);
        step(4'b1111, SEQ,    WRAP8,  0, 1, 3, 3, 0);
        step(4'b1111, SEQ,    WRAP8,  0, 1, 3, 3, 0);
        step(4'b1111, IDLE,   SINGLE, 0, 1, 0, 3, 0);
        step(4'b1111, NONSEQ, INCR4,  0, 1, 0, 0, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 0, 0, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 0, 0, 0);
        step(4'b1111, SEQ,    INCR4,  0, 1, 1, 0, 0);

        // Undefined-length INCR, owner drops req mid-burst
        step(4'b1111, NONSEQ, INCR,   0, 1, 1, 1, 0);
        step(4'b1111, SEQ,    INCR,   0, 1, 1, 1, 0);
        step(4'b1111, BUSY,   INCR,   0, 1, 1, 1, 0);
        step(4'b1101, SEQ,    INCR,   0, 1, 1, 1, 0);
        step(4'b1101, NONSEQ, INCR,   0, 1, 2, 1, 0);

        // Sole requester re-wins; default grant leaves the pointer alone; ARB stall
        step(4'b0100, IDLE,   SINGLE, 0, 1, 2, 2, 0);
        step(4'b0000, IDLE,   SINGLE, 0, 1, 0, 2, 0);
        step(4'b1011, IDLE,   SINGLE, 0, 1, 3, 0, 0);
        step(4'b1111, IDLE,   SINGLE, 0, 0, 3, 0, 0);
        step(4'b1111, IDLE,   SINGLE, 0, 1, 0, 3, 0);

        // Long lock: forced release with the timeout feature, held otherwise
        step(4'b0010, IDLE,   SINGLE, 0, 1, 1, 0, 0);
        step(4'b1111, NONSEQ, SINGLE, 1, 1, 1, 1, 0);
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
        for (int k = 0; k < 8; k++) step(4'b1111, NONSEQ, SINGLE, 1, 1, 1, 1, 0);
        step(4'b1111, NONSEQ, SINGLE, 1, 1, 2, 1, 1);
        step(4'b1111, IDLE,   SINGLE, 0, 1, 3, 2, 0);
        cur = 3;
`else
        for (int k = 0; k < 19; k++) step(4'b1111, NONSEQ, SINGLE, 1, 1, 1, 1, 0);
        step(4'b1111, IDLE,   SINGLE, 0, 1, 2, 1, 0);
        cur = 2;
`endif

        // Asynchronous reset in the middle of an INCR8
        step(4'b1111, NONSEQ, INCR8,  0, 1, cur, cur, 0);
        step(4'b1111, SEQ,    INCR8,  0, 1, cur, cur, 0);
        drain();
        HRESETn = 1'b0;
        #1;
        check("async_rst grant_id", step_no, int'(bus.grant_id), 0);
        check("async_rst granted", step_no, int'(bus.granted), 1);
        check("async_rst grantedD", step_no, int'(bus.grantedD), 1);
        check("async_rst lock_timeout", step_no, int'(bus.lock_timeout), 0);
        step(4'b1111, SEQ,    INCR8,  0, 1, 0, 0, 0);
        @(negedge HCLK);
        bus.req    = '0;
        bus.HTRANS = IDLE;
        bus.HBURST = SINGLE;
        HRESETn    = 1'b1;
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 1, 0, 0);
        step(4'b1111, NONSEQ, SINGLE, 0, 1, 2, 1, 0);

        drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
